pc_fetch_unit: RTL
==================

# pc_fetch_unit

Program-counter and instruction-fetch stage of the RISC datapath. Holds the architectural PC and presents it to instruction memory. It forms the sequential next-PC (PC + 4, same arithmetic as the adder stage it feeds) and applies branch, jump and halt control from decode. It hands each fetched instruction to decode with a valid/stall handshake.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch address (always equals pc_out)
- imem_ready  in  1  memory has valid data on imem_rdata this cycle
- imem_rdata  in  32  instruction word from memory
- instr  out  32  latched instruction for decode
- instr_valid  out  1  instr is valid and awaiting acceptance
- stall  in  1  decode cannot accept instr this cycle
- br_taken  in  1  conditional branch taken
- br_target  in  32  branch target address
- jump  in  1  unconditional jump/JR
- jump_target  in  32  jump target address
- halt  in  1  stop fetching after current instruction
- pc_out  out  32  current PC
- pc_plus4  out  32  pc_out + 4, combinational
- halted  out  1  unit is in HALTED state
- misalign_fault  out  1  only when ALIGN_CHECK_EN defined

## Operation
- FSM states: BOOT, FETCH, ISSUE, HALTED.
- BOOT: imem_req=0, instr_valid=0. Always moves to FETCH next cycle.
- FETCH: imem_req=1, imem_addr=pc. On imem_ready=1, instr <= imem_rdata and move to ISSUE. Otherwise hold with the request asserted.
- ISSUE: instr_valid=1, imem_req=0.
  - stall=1: hold state, instr and pc; redirect and halt inputs are ignored.
  - stall=0: instruction accepted; resolve the next state as below.
- Acceptance in ISSUE, highest priority first:
  - halt=1: go to HALTED; pc unchanged.
  - jump=1: pc <= jump_target.
  - br_taken=1: pc <= br_target.
  - Otherwise: pc <= pc_plus4.
  - Then move to FETCH.
- HALTED: imem_req=0, instr_valid=0, halted=1. Only rst leaves this state.
- Arithmetic: pc_plus4 wraps modulo 2^32, so 32'hFFFF_FFFC gives 32'h0000_0000. Targets are 32-bit with no sign extension in this block.
- Redirect inputs are sampled only in ISSUE with stall=0. Values presented in any other state have no effect.

## Timing
- Reset values:
  - pc_out = RESET_PC and state = BOOT.
  - instr = 0.
  - instr_valid, imem_req, halted and misalign_fault are 0.
- rst is sampled on every edge and overrides everything, including mid-fetch and an ISSUE held by stall. The pending instruction is discarded.
- The first imem_req appears in cycle 1 after the cycle rst was sampled low (BOOT occupies cycle 0).
- With zero-wait memory (imem_ready=1 in the same FETCH cycle), instr_valid rises one cycle after FETCH. Steady-state throughput is one instruction per 2 cycles.
- Each memory wait cycle adds one cycle of FETCH.
- The new pc is visible on pc_out and imem_addr in the cycle after acceptance.
- imem_rdata is ignored whenever imem_ready=0 or the state is not FETCH.

## Configuration
- ALIGN_CHECK_EN defined:
  - If a selected jump or branch target has bits [1:0] != 0, pc is not updated.
  - misalign_fault <= 1 (sticky until rst) and the FSM goes to HALTED.
  - Fetch PC +4 sequencing is unaffected.
- ALIGN_CHECK_EN not defined:
  - The misalign_fault port is absent.
  - Target bits [1:0] are forced to 0 before loading pc.

## Test plan
- Reset, then release with RESET_PC=0 and imem_ready=1 held -> imem_addr = 0, 4, 8 on successive FETCH cycles; instr_valid high every second cycle; instr matches imem_rdata.
- Hold imem_ready=0 for 3 FETCH cycles, then 1 -> imem_req stays high for 4 cycles; imem_addr is constant; one instr_valid pulse follows.
- In ISSUE at pc=0x10, assert stall for 2 cycles with br_taken=1 and br_target=0x40, then drop stall with both still held -> first 2 cycles: pc stays 0x10 and redirect is ignored. On release: next fetch is at 0x40.
- In ISSUE, assert jump=1 (jump_target=0x80) and br_taken=1 (br_target=0x40) together with stall=0 -> next imem_addr = 0x80.
- Set pc to 0xFFFF_FFFC via jump, then accept without redirect -> next imem_addr = 0x0000_0000.
- Assert halt with jump=1 in ISSUE -> halted=1, pc unchanged, no further imem_req. Then assert rst mid-FETCH -> pc returns to RESET_PC and the FSM restarts at BOOT. With ALIGN_CHECK_EN, jump_target=0x102 -> misalign_fault=1 and halted=1.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and instruction fetch stage.
// Holds the architectural PC and drives instruction memory with it. Each fetched
// word is handed to decode with a valid/stall handshake. Branch, jump and halt
// requests are taken only when decode accepts the instruction.
// Optional build macro: ALIGN_CHECK_EN. When it is defined, a misaligned redirect
// target raises a sticky misalign_fault and halts the unit. When it is not
// defined, the target's low two bits are cleared before the PC is loaded.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        halt,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        halted
`ifdef ALIGN_CHECK_EN
  ,
  output logic        misalign_fault
`endif
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    ISSUE  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t      state;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] next_pc;
`ifdef ALIGN_CHECK_EN
  logic        misaligned;
`endif

  // Clear the byte offset so the PC always points at a whole word.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Sequential PC; the 32-bit add wraps modulo 2^32 on its own.
  assign pc_plus4  = pc_out + 32'd4;
  assign imem_addr = pc_out;

  // Select the next PC. A jump wins over a branch, and a redirect wins over sequential flow.
  always_comb begin
    redirect = jump | br_taken;
    target   = jump ? jump_target : br_target;
    next_pc  = redirect ? word_align(target) : pc_plus4;
`ifdef ALIGN_CHECK_EN
    misaligned = redirect && (target[1:0] != 2'b00);
`endif
  end

  // Fetch FSM. The handshake outputs are registered next to the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      pc_out      <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      halted      <= 1'b0;
`ifdef ALIGN_CHECK_EN
      misalign_fault <= 1'b0;
`endif
    end else begin
      case (state)
        BOOT: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          // Keep requesting until memory returns data. rdata matters only on a ready cycle.
          if (imem_ready) begin
            instr       <= imem_rdata;
            state       <= ISSUE;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        ISSUE: begin
          // While decode stalls, hold everything and ignore control inputs.
          if (!stall) begin
            instr_valid <= 1'b0;
            if (halt) begin
              state  <= HALTED;
              halted <= 1'b1;
`ifdef ALIGN_CHECK_EN
            end else if (misaligned) begin
              // Keep the PC at the faulting instruction so it can be inspected.
              state          <= HALTED;
              halted         <= 1'b1;
              misalign_fault <= 1'b1;
`endif
            end else begin
              pc_out   <= next_pc;
              state    <= FETCH;
              imem_req <= 1'b1;
            end
          end
        end
        HALTED: begin
          // Only reset leaves this state.
          state <= HALTED;
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

endmodule
